scan_timebase: RTL and testbench

Parametrised, fully synchronous timebase for the LED-matrix and display scan path. It replaces a ripple chain of toggle flip-flops with one clock domain: single-cycle clock-enable ticks, a row selector that wraps at an arbitrary row count, and an image selector that toggles every N frames. It sits between the board clock and the matrix/display drivers, which consume its ticks as enables rather than as derived clocks.

---
 rtl/scan_timebase.sv | 128 ++++++++++++
 tb/tb_scan_timebase.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scan_timebase.sv
// Synchronous scan timebase: clock-enable ticks for display and row scanning,
// a wrapping row selector and an image selector toggled every IMG_FRAMES frames.
module scan_timebase #(
    parameter int DISP_DIV   = 4,
    parameter int ROW_DIV    = 32768,
    parameter int ROWS       = 8,
    parameter int IMG_FRAMES = 32,
    parameter int ROW_W      = $clog2(ROWS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_clear,
    output logic             o_disp_tick,
    output logic             o_row_tick,
    output logic             o_frame_tick,
    output logic [ROW_W-1:0] o_row_sel,
    output logic             o_image_sel
);

    localparam int DISP_W  = (DISP_DIV > 1)   ? $clog2(DISP_DIV)   : 1;
    localparam int ROWC_W  = (ROW_DIV > 1)    ? $clog2(ROW_DIV)    : 1;
    localparam int FRAME_W = (IMG_FRAMES > 1) ? $clog2(IMG_FRAMES) : 1;

    localparam logic [DISP_W-1:0]  DISP_LAST  = DISP_W'(DISP_DIV - 1);
    localparam logic [DISP_W-1:0]  DISP_INC   = DISP_W'(1);
    localparam logic [ROWC_W-1:0]  ROWC_LAST  = ROWC_W'(ROW_DIV - 1);
    localparam logic [ROWC_W-1:0]  ROWC_INC   = ROWC_W'(1);
    localparam logic [ROW_W-1:0]   SEL_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]   SEL_INC    = ROW_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(IMG_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_INC  = FRAME_W'(1);

    logic [DISP_W-1:0]  r_disp_cnt;
    logic [ROWC_W-1:0]  r_row_cnt;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [ROW_W-1:0]   r_row_sel;
    logic               r_disp_tick;
    logic               r_row_tick;
    logic               r_frame_tick;
    logic               r_image_sel;

    logic w_disp_wrap;
    logic w_row_wrap;
    logic w_sel_wrap;
    logic w_frame_wrap;
    logic w_frame_evt;

    assign w_disp_wrap  = (r_disp_cnt == DISP_LAST);
    assign w_row_wrap   = (r_row_cnt == ROWC_LAST);
    assign w_sel_wrap   = (r_row_sel == SEL_LAST);
    assign w_frame_wrap = (r_frame_cnt == FRAME_LAST);
    // Edge on which frame_tick is being raised; drives the image path.
    assign w_frame_evt  = i_run && w_row_wrap && w_sel_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_disp_cnt  <= '0;
            r_disp_tick <= 1'b0;
        end else if (i_clear) begin
            r_disp_cnt  <= '0;
            r_disp_tick <= 1'b0;
        end else if (!i_run) begin
            r_disp_tick <= 1'b0;
        end else if (w_disp_wrap) begin
            r_disp_cnt  <= '0;
            r_disp_tick <= 1'b1;
        end else begin
            r_disp_cnt  <= r_disp_cnt + DISP_INC;
            r_disp_tick <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_cnt    <= '0;
            r_row_tick   <= 1'b0;
            r_row_sel    <= '0;
            r_frame_tick <= 1'b0;
        end else if (i_clear) begin
            r_row_cnt    <= '0;
            r_row_tick   <= 1'b0;
            r_row_sel    <= '0;
            r_frame_tick <= 1'b0;
        end else if (!i_run) begin
            r_row_tick   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (w_row_wrap) begin
            r_row_cnt  <= '0;
            r_row_tick <= 1'b1;
            if (w_sel_wrap) begin
                r_row_sel    <= '0;
                r_frame_tick <= 1'b1;
            end else begin
                r_row_sel    <= r_row_sel + SEL_INC;
                r_frame_tick <= 1'b0;
            end
        end else begin
            r_row_cnt    <= r_row_cnt + ROWC_INC;
            r_row_tick   <= 1'b0;
            r_frame_tick <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
            r_image_sel <= 1'b0;
        end else if (i_clear) begin
            r_frame_cnt <= '0;
            r_image_sel <= 1'b0;
        end else if (w_frame_evt) begin
            if (w_frame_wrap) begin
                r_frame_cnt <= '0;
                r_image_sel <= ~r_image_sel;
            end else begin
                r_frame_cnt <= r_frame_cnt + FRAME_INC;
            end
        end
    end

    assign o_disp_tick  = r_disp_tick;
    assign o_row_tick   = r_row_tick;
    assign o_frame_tick = r_frame_tick;
    assign o_row_sel    = r_row_sel;
    assign o_image_sel  = r_image_sel;

endmodule

// File: tb/tb_scan_timebase.sv
// Directed bench for scan_timebase: cadence, pause, clear, async reset,
// degenerate divisors and a scaled long run.
module tb_scan_timebase;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: DISP_DIV=2, ROW_DIV=4, ROWS=3, IMG_FRAMES=2
    logic       rst_a, run_a, clr_a;
    logic       disp_a, row_a, frame_a, img_a;
    logic [1:0] sel_a;
    scan_timebase #(.DISP_DIV(2), .ROW_DIV(4), .ROWS(3), .IMG_FRAMES(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_run(run_a), .i_clear(clr_a),
        .o_disp_tick(disp_a), .o_row_tick(row_a), .o_frame_tick(frame_a),
        .o_row_sel(sel_a), .o_image_sel(img_a)
    );

    // Instance B: all divisors degenerate
    logic       rst_b, run_b, clr_b;
    logic       disp_b, row_b, frame_b, img_b;
    logic [0:0] sel_b;
    scan_timebase #(.DISP_DIV(1), .ROW_DIV(1), .ROWS(2), .IMG_FRAMES(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_run(run_b), .i_clear(clr_b),
        .o_disp_tick(disp_b), .o_row_tick(row_b), .o_frame_tick(frame_b),
        .o_row_sel(sel_b), .o_image_sel(img_b)
    );

    // Instance C: default ROWS/IMG_FRAMES, short dividers so a full image period fits
    logic       rst_c, run_c, clr_c;
    logic       disp_c, row_c, frame_c, img_c;
    logic [2:0] sel_c;
    scan_timebase #(.DISP_DIV(4), .ROW_DIV(8), .ROWS(8), .IMG_FRAMES(32)) dut_c (
        .i_clk(clk), .i_rst_n(rst_c), .i_run(run_c), .i_clear(clr_c),
        .o_disp_tick(disp_c), .o_row_tick(row_c), .o_frame_tick(frame_c),
        .o_row_sel(sel_c), .o_image_sel(img_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected A outputs after the n-th enabled edge of an uninterrupted run from zero
    task automatic chk_sched_a(input string tag, input int n);
        chk($sformatf("%s_disp%0d", tag, n),  32'(disp_a),  32'((n % 2) == 0));
        chk($sformatf("%s_row%0d", tag, n),   32'(row_a),   32'((n % 4) == 0));
        chk($sformatf("%s_sel%0d", tag, n),   32'(sel_a),   32'((n / 4) % 3));
        chk($sformatf("%s_frame%0d", tag, n), 32'(frame_a), 32'((n % 12) == 0));
        chk($sformatf("%s_img%0d", tag, n),   32'(img_a),   32'((n / 24) % 2));
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_disp"},  32'(disp_a),  32'd0);
        chk({tag, "_row"},   32'(row_a),   32'd0);
        chk({tag, "_frame"}, 32'(frame_a), 32'd0);
        chk({tag, "_sel"},   32'(sel_a),   32'd0);
        chk({tag, "_img"},   32'(img_a),   32'd0);
    endtask

    initial begin
        int cnt_disp, cnt_row, cnt_frame, tog1, tog2;
        logic prev_img;

        rst_a = 1'b0; run_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b0; run_b = 1'b0; clr_b = 1'b0;
        rst_c = 1'b0; run_c = 1'b0; clr_c = 1'b0;
        #2;
        chk_zero_a("rst");
        step();
        step();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        run_a = 1'b1;

        // Basic cadence
        for (int n = 1; n <= 40; n++) begin
            step();
            chk_sched_a("cad", n);
        end

        // Pause on a would-be row tick
        rst_a = 1'b0;
        #1;
        chk_zero_a("rst2");
        rst_a = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            chk_sched_a("pre", n);
        end
        run_a = 1'b0;
        for (int p = 0; p < 3; p++) begin
            step();
            chk($sformatf("pause_disp%0d", p), 32'(disp_a), 32'd0);
            chk($sformatf("pause_row%0d", p),  32'(row_a),  32'd0);
            chk($sformatf("pause_sel%0d", p),  32'(sel_a),  32'd0);
        end
        run_a = 1'b1;
        step();
        chk("post_row",   32'(row_a),   32'd1);
        chk("post_sel",   32'(sel_a),   32'd1);
        chk("post_disp",  32'(disp_a),  32'd1);
        chk("post_frame", 32'(frame_a), 32'd0);

        // Clear on the edge that would wrap row_sel 2 -> 0
        for (int n = 5; n <= 11; n++) begin
            step();
            chk_sched_a("run", n);
        end
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk_zero_a("clr");
        for (int n = 1; n <= 4; n++) begin
            step();
            chk_sched_a("aclr", n);
        end

        // Async reset with image_sel=1, row_sel=2
        for (int n = 5; n <= 33; n++) begin
            step();
            chk_sched_a("arun", n);
        end
        #2;
        rst_a = 1'b0;
        #1;
        chk_zero_a("async");
        for (int k = 0; k < 3; k++) begin
            step();
            chk_zero_a($sformatf("hold%0d", k));
        end
        rst_a = 1'b1;
        run_a = 1'b0;

        // Degenerate divisors
        run_b = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step();
            chk($sformatf("deg_disp%0d", n),  32'(disp_b),  32'd1);
            chk($sformatf("deg_row%0d", n),   32'(row_b),   32'd1);
            chk($sformatf("deg_sel%0d", n),   32'(sel_b),   32'(n % 2));
            chk($sformatf("deg_frame%0d", n), 32'(frame_b), 32'((n % 2) == 0));
            chk($sformatf("deg_img%0d", n),   32'(img_b),   32'((n / 2) % 2));
        end
        run_b = 1'b0;
        step();
        chk("degp_disp", 32'(disp_b), 32'd0);
        chk("degp_row",  32'(row_b),  32'd0);
        chk("degp_sel",  32'(sel_b),  32'd1);
        chk("degp_img",  32'(img_b),  32'd1);

        // Scaled long run: image period 2*8*8*32 cycles
        cnt_disp = 0; cnt_row = 0; cnt_frame = 0; tog1 = 0; tog2 = 0;
        prev_img = 1'b0;
        run_c = 1'b1;
        for (int n = 1; n <= 4096; n++) begin
            step();
            if (disp_c)  cnt_disp++;
            if (row_c)   cnt_row++;
            if (frame_c) cnt_frame++;
            if (img_c !== prev_img) begin
                if (tog1 == 0) tog1 = n;
                else if (tog2 == 0) tog2 = n;
            end
            prev_img = img_c;
        end
        chk("long_disp",  32'(cnt_disp),  32'd1024);
        chk("long_row",   32'(cnt_row),   32'd512);
        chk("long_frame", 32'(cnt_frame), 32'd64);
        chk("long_tog1",  32'(tog1),      32'd2048);
        chk("long_tog2",  32'(tog2),      32'd4096);
        chk("long_sel",   32'(sel_c),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
